ahbl_uart_tx: RTL and testbench

AHB-Lite slave implementing a transmit-only UART (8N1, LSB first) with an internal byte FIFO and a programmable baud divider. It occupies the S3 slot at 0x8000_0000 of the SoC splitter, which currently has no slave. It gives the Hazard2 CPU a console and debug output path. The slave has zero wait states; the transmit FSM drains the FIFO autonomously.

---
 rtl/uart_pkg.sv | 35 +++
 rtl/uart_tx_fifo.sv | 49 ++++
 rtl/ahbl_uart_tx.sv | 177 +++++++++++++++++
 tb/tb_ahbl_uart_tx.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the AHB-Lite transmit-only UART: register map,
// status/control bit positions, TX state encoding and the reset baud divider.
package uart_pkg;

    localparam logic [1:0] REG_DATA    = 2'd0;
    localparam logic [1:0] REG_STATUS  = 2'd1;
    localparam logic [1:0] REG_BAUDDIV = 2'd2;
    localparam logic [1:0] REG_CTRL    = 2'd3;

    localparam int STAT_BUSY    = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_EMPTY   = 2;
    localparam int STAT_OVF     = 3;
    localparam int STAT_LVL_LSB = 8;

    localparam int CTRL_EN = 0;
    localparam int CTRL_IE = 1;

    // 433 -> 115200 baud from a 50 MHz HCLK
    localparam logic [15:0] DEF_DIV = 16'd433;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } tx_state_t;

    typedef struct packed {
        logic       valid;
        logic       write;
        logic [1:0] addr;
    } ahb_dp_t;

endpackage

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO with a level counter; a push while full is accepted
// only when a pop frees the head slot in the same cycle.
module uart_tx_fifo #(
    parameter int unsigned FIFO_DEPTH = 8,
    localparam int unsigned PW = $clog2(FIFO_DEPTH),
    localparam int unsigned LW = $clog2(FIFO_DEPTH + 1)
) (
    input  logic          HCLK,
    input  logic          HRESET,
    input  logic          push,
    input  logic [7:0]    wdata,
    input  logic          pop,
    output logic [7:0]    rdata,
    output logic [LW-1:0] level,
    output logic          full,
    output logic          empty
);

    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wptr, rptr;
    logic          do_push, do_pop;

    assign full    = (level == LW'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign rdata   = mem[rptr];

    always_ff @(posedge HCLK) begin
        if (do_push) mem[wptr] <= wdata;
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (do_push) wptr <= wptr + 1'b1;
            if (do_pop)  rptr <= rptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

endmodule

// File: rtl/ahbl_uart_tx.sv
// AHB-Lite zero-wait-state slave wrapping a FIFO-fed 8N1 UART transmitter
// with a programmable per-frame baud divider and a level interrupt.
module ahbl_uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = DEF_DIV
) (
    input  logic        HCLK,
    input  logic        HRESET,
    input  logic        HSEL,
    input  logic [31:0] HADDR,
    input  logic [1:0]  HTRANS,
    input  logic [2:0]  HSIZE,
    input  logic        HWRITE,
    input  logic        HREADY,
    input  logic [31:0] HWDATA,
    output logic        HREADYOUT,
    output logic [31:0] HRDATA,
    output logic        TX,
    output logic        IRQ
);

    localparam int unsigned LW = $clog2(FIFO_DEPTH + 1);

    ahb_dp_t       dp;
    logic [15:0]   baud_div;
    logic          ctrl_en, ctrl_ie, ovf, irq_q;
    tx_state_t     state, state_nx;
    logic [15:0]   timer, frame_div;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          fifo_pop, fifo_full, fifo_empty, load, shift;
    logic [7:0]    fifo_rdata;
    logic [LW-1:0] fifo_level;
    logic          wr_data, wr_status, wr_baud, wr_ctrl;
    logic          unused_bits;

    assign unused_bits = ^{HSIZE, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:16]};

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            dp <= '0;
        end else begin
            dp.valid <= HSEL & HREADY & HTRANS[1];
            dp.write <= HWRITE;
            dp.addr  <= HADDR[3:2];
        end
    end

    assign wr_data   = dp.valid & dp.write & (dp.addr == REG_DATA);
    assign wr_status = dp.valid & dp.write & (dp.addr == REG_STATUS);
    assign wr_baud   = dp.valid & dp.write & (dp.addr == REG_BAUDDIV);
    assign wr_ctrl   = dp.valid & dp.write & (dp.addr == REG_CTRL);

    uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
        .HCLK  (HCLK),
        .HRESET(HRESET),
        .push  (wr_data),
        .wdata (HWDATA[7:0]),
        .pop   (fifo_pop),
        .rdata (fifo_rdata),
        .level (fifo_level),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            baud_div <= DEFAULT_DIV;
            ctrl_en  <= 1'b1;
            ctrl_ie  <= 1'b0;
            ovf      <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (wr_baud) baud_div <= (HWDATA[15:0] == 16'd0) ? 16'd1 : HWDATA[15:0];
            if (wr_ctrl) begin
                ctrl_en <= HWDATA[CTRL_EN];
                ctrl_ie <= HWDATA[CTRL_IE];
            end
            // a full FIFO still takes the byte if the FSM frees a slot this cycle
            if (wr_data & fifo_full & ~fifo_pop)  ovf <= 1'b1;
            else if (wr_status & HWDATA[STAT_OVF]) ovf <= 1'b0;
            irq_q <= ctrl_ie & fifo_empty & (state == ST_IDLE);
        end
    end

    always_comb begin
        state_nx = state;
        fifo_pop = 1'b0;
        load     = 1'b0;
        shift    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (ctrl_en & ~fifo_empty) begin
                    state_nx = ST_START;
                    fifo_pop = 1'b1;
                    load     = 1'b1;
                end
            end
            ST_START: begin
                if (timer == 16'd0) state_nx = ST_DATA;
            end
            ST_DATA: begin
                if (timer == 16'd0) begin
                    shift = 1'b1;
                    if (bit_idx == 3'd7) state_nx = ST_STOP;
                end
            end
            ST_STOP: begin
                if (timer == 16'd0) begin
                    if (ctrl_en & ~fifo_empty) begin
                        state_nx = ST_START;
                        fifo_pop = 1'b1;
                        load     = 1'b1;
                    end else begin
                        state_nx = ST_IDLE;
                    end
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    // divider is latched per frame so BAUDDIV writes never distort a frame in flight
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state     <= ST_IDLE;
            timer     <= 16'd0;
            frame_div <= 16'd0;
            bit_idx   <= 3'd0;
            shreg     <= 8'hFF;
        end else begin
            state <= state_nx;
            if (load) begin
                shreg     <= fifo_rdata;
                frame_div <= baud_div;
                timer     <= baud_div;
                bit_idx   <= 3'd0;
            end else if (state != ST_IDLE) begin
                if (timer == 16'd0) begin
                    timer <= frame_div;
                    if (shift) begin
                        shreg   <= {1'b1, shreg[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                    end
                end else begin
                    timer <= timer - 16'd1;
                end
            end
        end
    end

    always_comb begin
        HRDATA = '0;
        if (dp.valid & ~dp.write) begin
            case (dp.addr)
                REG_STATUS: begin
                    HRDATA[STAT_BUSY]          = (state != ST_IDLE);
                    HRDATA[STAT_FULL]          = fifo_full;
                    HRDATA[STAT_EMPTY]         = fifo_empty;
                    HRDATA[STAT_OVF]           = ovf;
                    HRDATA[STAT_LVL_LSB +: 8]  = 8'(fifo_level);
                end
                REG_BAUDDIV: HRDATA[15:0] = baud_div;
                REG_CTRL:    HRDATA[1:0]  = {ctrl_ie, ctrl_en};
                default:     HRDATA       = '0;
            endcase
        end
    end

    assign TX        = (state == ST_START) ? 1'b0 :
                       (state == ST_DATA)  ? shreg[0] : 1'b1;
    assign IRQ       = irq_q;
    assign HREADYOUT = 1'b1;

endmodule

// File: tb/tb_ahbl_uart_tx.sv
// Randomized bench: a line-level monitor decodes every frame from TX and
// compares it against a queue of bytes the bench expects to be sent.
module tb_ahbl_uart_tx;

    localparam int DEPTH = 8;

    logic        clk = 0;
    logic        HRESET = 1;
    logic        HSEL = 0;
    logic [31:0] HADDR = '0;
    logic [1:0]  HTRANS = '0;
    logic [2:0]  HSIZE = 3'd2;
    logic        HWRITE = 0;
    logic        HREADY = 1;
    logic [31:0] HWDATA = '0;
    logic        HREADYOUT;
    logic [31:0] HRDATA;
    logic        TX;
    logic        IRQ;

    int n_cmp = 0;
    int n_err = 0;

    logic [7:0] exp_q[$];
    int         m_div = 433;
    bit         m_en = 1, m_ie = 0, m_ovf = 0;
    bit         mon_busy = 0, mon_abort = 0;

    ahbl_uart_tx #(.FIFO_DEPTH(DEPTH)) dut (
        .HCLK(clk), .HRESET(HRESET), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HSIZE(HSIZE), .HWRITE(HWRITE), .HREADY(HREADY), .HWDATA(HWDATA),
        .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .TX(TX), .IRQ(IRQ)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] st_exp(int lvl, bit ovf, bit busy);
        int v;
        v = lvl * 256 + (ovf ? 8 : 0) + (lvl == 0 ? 4 : 0) + (lvl == DEPTH ? 2 : 0) + (busy ? 1 : 0);
        return 32'(v);
    endfunction

    task automatic ahb_write(input logic [3:0] off, input logic [31:0] d);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 1; HADDR = {28'h8000000, off};
        tick();
        HSEL = 0; HTRANS = 2'b00; HWRITE = 0; HWDATA = d;
        tick();
        case (off)
            4'h0: if (exp_q.size() < DEPTH) exp_q.push_back(d[7:0]); else m_ovf = 1;
            4'h4: if (d[3]) m_ovf = 0;
            4'h8: m_div = (d[15:0] == 16'd0) ? 1 : int'(d[15:0]);
            4'hC: begin m_en = d[0]; m_ie = d[1]; end
            default: ;
        endcase
    endtask

    task automatic ahb_read(input logic [3:0] off, output logic [31:0] d);
        HSEL = 1; HTRANS = 2'b10; HWRITE = 0; HADDR = {28'h8000000, off};
        tick();
        HSEL = 0; HTRANS = 2'b00;
        d = HRDATA;
        tick();
    endtask

    task automatic wait_drain();
        int i;
        for (i = 0; i < 5000 && (exp_q.size() != 0 || mon_busy); i++) tick();
        chk("drain_timeout", 32'(exp_q.size() == 0 && !mon_busy), 32'd1);
    endtask

    // line monitor: every frame is 10 bits of (div+1) cycles each, div taken at frame start
    initial begin : mon
        logic [7:0] b;
        logic [9:0] frame, got;
        int         d, errs;
        bit         aborted, need_b2b;
        need_b2b = 0;
        forever begin
            @(negedge clk);
            if (mon_abort) begin
                exp_q.delete(); mon_abort = 0; need_b2b = 0;
                continue;
            end
            if (need_b2b) begin
                chk("b2b_start", 32'(TX), 32'd0);
                need_b2b = 0;
            end
            if (TX === 1'b0) begin
                if (!m_en || exp_q.size() == 0) begin
                    chk("unexpected_start", 32'(TX), 32'd1);
                end else begin
                    mon_busy = 1;
                    b = exp_q.pop_front();
                    d = m_div;
                    frame = {1'b1, b, 1'b0};
                    errs = 0; aborted = 0; got = '0;
                    for (int k = 0; k < 10 * (d + 1); k++) begin
                        if (k > 0) @(negedge clk);
                        if (mon_abort) begin aborted = 1; break; end
                        if (TX !== frame[k / (d + 1)]) errs++;
                        if (k % (d + 1) == d / 2) got[k / (d + 1)] = TX;
                    end
                    mon_busy = 0;
                    if (aborted) begin
                        exp_q.delete(); mon_abort = 0;
                    end else begin
                        chk("frame_byte", 32'(got[8:1]), 32'(b));
                        chk("frame_start_stop", 32'({got[9], got[0]}), 32'b10);
                        chk("frame_shape", 32'(errs), 32'd0);
                        need_b2b = (exp_q.size() > 0) && m_en;
                    end
                end
            end
        end
    end

    initial begin : stim
        logic [31:0] rd;
        logic [7:0]  byt;
        int          n, i;

        repeat (3) tick();
        HRESET = 0;
        chk("rst_tx", 32'(TX), 32'd1);
        chk("rst_irq", 32'(IRQ), 32'd0);
        chk("rst_hreadyout", 32'(HREADYOUT), 32'd1);
        chk("rst_hrdata", HRDATA, 32'd0);
        ahb_read(4'h4, rd); chk("rst_status", rd, st_exp(0, 0, 0));
        ahb_read(4'h8, rd); chk("rst_baud", rd, 32'h1B1);
        ahb_read(4'hC, rd); chk("rst_ctrl", rd, 32'h1);
        ahb_read(4'h0, rd); chk("data_read", rd, 32'h0);

        // single frame, exact start latency
        ahb_write(4'h8, 32'd3);
        ahb_write(4'h0, 32'hA5);
        chk("start_pre", 32'(TX), 32'd1);
        tick();
        chk("start_edge", 32'(TX), 32'd0);
        wait_drain();
        ahb_read(4'h4, rd); chk("status_idle", rd, st_exp(0, 0, 0));

        // fill while disabled, overflow, then release
        ahb_write(4'h8, 32'd1);
        ahb_write(4'hC, 32'h0);
        for (i = 0; i < 9; i++) ahb_write(4'h0, 32'($urandom_range(0, 255)));
        repeat (5) tick();
        chk("tx_disabled", 32'(TX), 32'd1);
        ahb_read(4'h4, rd); chk("status_full_ovf", rd, st_exp(exp_q.size(), m_ovf, 0));
        ahb_write(4'h4, 32'h8);
        ahb_read(4'h4, rd); chk("status_ovf_clr", rd, st_exp(exp_q.size(), m_ovf, 0));
        ahb_write(4'hC, 32'h1);
        wait_drain();
        ahb_read(4'h4, rd); chk("status_drained", rd, st_exp(0, 0, 0));

        // BAUDDIV change during frame 1 applies from frame 2
        ahb_write(4'h0, 32'($urandom_range(0, 255)));
        ahb_write(4'h0, 32'($urandom_range(0, 255)));
        ahb_write(4'h8, 32'd7);
        ahb_read(4'h8, rd); chk("baud_rb", rd, 32'd7);
        wait_drain();

        // interrupt behaviour
        ahb_write(4'h8, 32'd2);
        ahb_write(4'hC, 32'h3);
        tick();
        chk("irq_idle", 32'(IRQ), 32'd1);
        ahb_write(4'h0, 32'($urandom_range(0, 255)));
        repeat (6) tick();
        chk("irq_busy", 32'(IRQ), 32'd0);
        for (i = 0; i < 200 && mon_busy; i++) tick();
        chk("irq_wait_timeout", 32'(mon_busy), 32'd0);
        chk("irq_pre", 32'(IRQ), 32'd0);
        tick();
        chk("irq_set", 32'(IRQ), 32'd1);
        ahb_write(4'hC, 32'h1);
        chk("irq_hold", 32'(IRQ), 32'd1);
        tick();
        chk("irq_clr", 32'(IRQ), 32'd0);

        // randomized rounds
        for (int r = 0; r < 6; r++) begin
            ahb_write(4'h8, 32'($urandom_range(0, 3)));
            ahb_read(4'h8, rd); chk("rnd_baud", rd, 32'(m_div));
            n = $urandom_range(1, 3);
            for (int j = 0; j < n; j++) begin
                byt = 8'($urandom_range(0, 255));
                ahb_write(4'h0, {24'h0, byt});
            end
            wait_drain();
        end

        // reset mid-frame
        ahb_write(4'h8, 32'd3);
        ahb_write(4'h0, 32'h00);
        repeat (10) tick();
        chk("pre_reset_tx", 32'(TX), 32'd0);
        mon_abort = 1;
        HRESET = 1;
        tick();
        HRESET = 0;
        m_div = 433; m_en = 1; m_ie = 0; m_ovf = 0;
        chk("reset_tx", 32'(TX), 32'd1);
        chk("reset_irq", 32'(IRQ), 32'd0);
        ahb_read(4'h4, rd); chk("reset_status", rd, st_exp(0, 0, 0));
        ahb_read(4'h8, rd); chk("reset_baud", rd, 32'h1B1);
        repeat (50) tick();
        chk("reset_quiet", 32'(TX), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
